// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
// Holds the FSM state enum, the LFSR tap mask and the byte-lane merge.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  mask
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick response latencies.
// Ports: clk, rst_n (async, active-low), q (current register value).
module lfsr8
    import mem_responder_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic       fb;

    assign fb = ^(q_q & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= {q_q[6:0], fb};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port SRAM responder with programmable or LFSR-driven latency.
// Ports: clk/rst_n; req_* valid/ready request channel (addr, wen, wdata,
// wmask); rsp_* valid/ready response channel (rdata, err); lat_fixed_en
// and lat_fixed select a fixed extra latency instead of the LFSR one.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          MAX_LAT     = 7,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        lat_fixed_en,
    input  logic [2:0]  lat_fixed
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  MAX_L = 3'(MAX_LAT);

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [7:0]  lfsr_q;
    logic [4:0]  unused_lfsr;
    logic        req_fire;
    logic [2:0]  lat_raw;
    logic [2:0]  lat_d;
    logic        in_idle;
    logic [31:0] acc_addr;
    logic        acc_wen;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic [31:0] off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        enter_resp;
    logic        mem_we;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign unused_lfsr = lfsr_q[7:3];

    assign req_ready = rst_n & (state_q == IDLE);
    assign req_fire  = req_valid & req_ready;

    assign lat_raw = lat_fixed_en ? lat_fixed : lfsr_q[2:0];
    assign lat_d   = (lat_raw > MAX_L) ? MAX_L : lat_raw;

    // A zero-latency request reaches RESP straight from IDLE, before the
    // request fields are captured, so the access uses the live inputs.
    assign in_idle   = (state_q == IDLE);
    assign acc_addr  = in_idle ? req_addr  : addr_q;
    assign acc_wen   = in_idle ? req_wen   : wen_q;
    assign acc_wdata = in_idle ? req_wdata : wdata_q;
    assign acc_wmask = in_idle ? req_wmask : wmask_q;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the compare.
    assign off      = acc_addr - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[AW+1:2];

    assign enter_resp = (in_idle & req_fire & (lat_d == 3'd0))
                      | ((state_q == WAIT) & (cnt_q == 3'd1));
    assign mem_we     = enter_resp & acc_wen & in_range;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merge_bytes(mem[idx], acc_wdata, acc_wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        addr_q  <= req_addr;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        cnt_q   <= lat_d;
                        state_q <= (lat_d == 3'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (!acc_wen && in_range) ? mem[idx] : '0;
                rsp_err_q   <= !in_range;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and soak bench for mem_responder with a queue scoreboard.
// A second instance with MAX_LAT=2 exercises latency saturation.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        lat_fixed_en;
    logic [2:0]  lat_fixed;

    logic        s_req_valid, s_req_ready, s_req_wen;
    logic [31:0] s_req_addr, s_req_wdata;
    logic [3:0]  s_req_wmask;
    logic        s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata;
    logic        s_lat_fixed_en;
    logic [2:0]  s_lat_fixed;

    always #5 clk = ~clk;

    mem_responder u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .lat_fixed_en (lat_fixed_en),
        .lat_fixed    (lat_fixed)
    );

    mem_responder #(.MAX_LAT(2)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (s_req_valid),
        .req_ready    (s_req_ready),
        .req_addr     (s_req_addr),
        .req_wen      (s_req_wen),
        .req_wdata    (s_req_wdata),
        .req_wmask    (s_req_wmask),
        .rsp_valid    (s_rsp_valid),
        .rsp_ready    (1'b1),
        .rsp_rdata    (s_rsp_rdata),
        .rsp_err      (s_rsp_err),
        .lat_fixed_en (s_lat_fixed_en),
        .lat_fixed    (s_lat_fixed)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [31:0] model [int];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o,
                                           input logic [31:0] w,
                                           input logic [3:0]  m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = w[b*8 +: 8];
        end
        return r;
    endfunction

    // exp_lat < 0: latency only bounded (LFSR mode); hold: rsp_ready low cycles
    task automatic txn(input string tag, input logic [31:0] addr,
                       input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic len,
                       input logic [2:0] lat, input int exp_lat,
                       input int hold);
        exp_t   e;
        exp_t   got;
        longint a;
        int     wi;
        int     n;
        bit     inr;
        a   = longint'(addr);
        inr = (a >= 64'h8000_0000) && (a < 64'h8000_0000 + 4096);
        e.err   = !inr;
        e.rdata = 32'h0;
        if (inr) begin
            wi = int'((a - 64'h8000_0000) / 4);
            if (wen) begin
                model[wi] = bmerge(model.exists(wi) ? model[wi] : 32'h0,
                                   wdata, wmask);
            end else begin
                e.rdata = model.exists(wi) ? model[wi] : 32'h0;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        rsp_ready    = (hold == 0);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wen      = wen;
        req_wdata    = wdata;
        req_wmask    = wmask;
        lat_fixed_en = len;
        lat_fixed    = lat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_req_timeout"}, 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(negedge clk);
        req_valid    = 1'b0;
        lat_fixed_en = ~len;
        lat_fixed    = ~lat;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'(1));
            void'(sb.pop_front());
            rsp_ready = 1'b1;
            return;
        end
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        else check({tag, "_lat_bound"}, 64'(n >= 1 && n <= 8), 64'(1));
        got = sb.pop_front();
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
        check({tag, "_err"}, 64'(rsp_err), 64'(got.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"},
                  {29'h0, rsp_valid, req_ready, rsp_err, rsp_rdata},
                  {29'h0, 1'b1, 1'b0, got.err, got.rdata});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, {62'h0, rsp_valid, req_ready}, 64'h1);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [31:0] ad;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        lat_fixed_en = 1'b1; lat_fixed = 3'd0;
        s_req_valid = 1'b0; s_req_addr = '0; s_req_wen = 1'b0;
        s_req_wdata = '0; s_req_wmask = '0;
        s_lat_fixed_en = 1'b1; s_lat_fixed = 3'd0;

        repeat (3) @(negedge clk);
        check("rst_outputs",
              {30'h0, req_ready, rsp_valid, rsp_err, rsp_rdata},
              64'h0);
        check("rst_sat_ready", 64'(s_req_ready), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'(1));

        txn("lat0_wr", 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'd0, 1, 0);
        txn("lat0_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1, 0);

        txn("mask_init", 32'h8000_0014, 1'b1, 32'hAAAA_AAAA, 4'hF, 1'b1, 3'd1, 2, 0);
        txn("mask_wr", 32'h8000_0014, 1'b1, 32'h1122_3344, 4'b0101, 1'b1, 3'd0, 1, 0);
        txn("mask_rd", 32'h8000_0017, 1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1, 0);
        check("mask_model", 64'(model[5]), 64'(32'hAA22_AA44));

        txn("lat5_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 3'd5, 6, 0);
        txn("bp_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 3'd2, 3, 10);

        txn("oor_init", 32'h8000_0000, 1'b1, 32'hC0FF_EE00, 4'hF, 1'b1, 3'd0, 1, 0);
        txn("oor_lo_rd", 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1, 0);
        txn("oor_hi_wr", 32'h8000_1000, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b1, 3'd3, 4, 0);
        txn("oor_chk_rd", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1, 0);
        txn("top_wr", 32'h8000_0FFC, 1'b1, 32'h7777_8888, 4'hF, 1'b1, 3'd0, 1, 0);
        txn("top_rd", 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 1'b1, 3'd7, 8, 0);

        txn("rstw_init", 32'h8000_0020, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 3'd0, 1, 0);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1;
        req_wdata = 32'h5555_5555; req_wmask = 4'hF;
        lat_fixed_en = 1'b1; lat_fixed = 3'd4;
        check("rstw_hs_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        check("rstw_in_rst", {62'h0, rsp_valid, req_ready}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rstw_no_rsp", 64'(seen), 64'(0));
        txn("rstw_rd", 32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b1, 3'd0, 1, 0);

        @(negedge clk);
        s_req_valid = 1'b1; s_req_addr = 32'h8000_0040; s_req_wen = 1'b1;
        s_req_wdata = 32'hFEED_FACE; s_req_wmask = 4'hF;
        s_lat_fixed_en = 1'b1; s_lat_fixed = 3'd7;
        check("sat_ready", 64'(s_req_ready), 64'(1));
        @(negedge clk);
        s_req_valid = 1'b0;
        n = 1;
        while (!s_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sat_lat", 64'(n), 64'(3));
        check("sat_rsp", {31'h0, s_rsp_err, s_rsp_rdata}, 64'h0);

        for (int i = 0; i < 16; i++) begin
            txn("soak_init", 32'h8000_0100 + 32'(4 * i), 1'b1, $urandom,
                4'hF, 1'b1, 3'd0, 1, 0);
        end
        for (int i = 0; i < 1000; i++) begin
            ad = 32'h8000_0100 + 32'($urandom_range(0, 15) * 4)
               + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ad = 32'h8000_2000 + 32'(4 * i);
            txn("soak", ad, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)), 1'b0, 3'd0, -1,
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
